// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-output FIFO into a valid/ready stream via a 2-entry buffer.
// Optional STREAM_RD_CNT_EN adds the xfer_count pop counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
`ifdef STREAM_RD_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  sclr_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            buf_level
`ifdef STREAM_RD_CNT_EN
  , output logic [CNT_WIDTH-1:0] xfer_count
`endif
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0] occ;
  logic [2:0] occ_next;
  logic inflight, wr_ptr, rd_ptr, pop;

  assign m_valid   = (occ != 2'd0);
  assign pop       = m_valid && m_ready;
  assign occ_next  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  // Reading against next-cycle occupancy keeps one slot free for the word still in flight.
  assign fifo_rd_en = aclr_n && sclr_n && !fifo_empty && (occ_next <= 3'd1);
  assign m_data    = mem[rd_ptr];
  assign buf_level = occ;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else if (!sclr_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ_next[1:0];
      if (inflight) begin
        mem[wr_ptr] <= fifo_dout;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef STREAM_RD_CNT_EN
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) xfer_count <= '0;
    else if (!sclr_n) xfer_count <= '0;
    else if (pop) xfer_count <= xfer_count + CNT_WIDTH'(1);
  end
`endif

  occ_bound: assert property (@(posedge clk) disable iff (!aclr_n) occ != 2'd3);
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: random and directed stimulus against a FIFO-order reference.
module tb_fifo_stream_reader;
  logic clk = 1'b0, aclr_n = 1'b0, sclr_n = 1'b1, m_ready = 1'b0;
  logic fifo_empty, fifo_rd_en, m_valid;
  logic [7:0] fifo_dout = 8'h00, m_data;
  logic [1:0] buf_level;
`ifdef STREAM_RD_CNT_EN
  logic [15:0] xfer_count;
`endif
  logic [7:0] fmem [0:1023];
  logic rd_log [0:4095];
  logic v_log [0:4095];
  logic [7:0] d_log [0:4095];
  int n_wr = 0, n_rd = 0, exp_idx = 0, cyc_n = 0, n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign fifo_empty = (n_rd == n_wr);

  fifo_stream_reader dut (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .buf_level(buf_level)
`ifdef STREAM_RD_CNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  // Source FIFO: registered read data, cleared together with the reader.
  always @(posedge clk or negedge aclr_n)
    if (!aclr_n || !sclr_n) n_rd <= n_wr;
    else if (fifo_rd_en) begin
      fifo_dout <= fmem[n_rd[9:0]];
      n_rd <= n_rd + 1;
    end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fmem[n_wr[9:0]] = w;
    n_wr++;
  endtask

  task automatic cyc();
    #1;
    if (aclr_n) begin
      chk("lvl_max", int'(buf_level <= 2'd2), 1);
      chk("valid_lvl", int'(m_valid), int'(buf_level != 2'd0));
      if (fifo_empty) chk("rd_while_empty", int'(fifo_rd_en), 0);
    end
    if (!aclr_n || !sclr_n) exp_idx = n_wr;
    else if (m_valid && m_ready) begin
      chk("extra_word", int'(exp_idx < n_wr), 1);
      chk("order", int'(m_data), int'(fmem[exp_idx[9:0]]));
      exp_idx++;
    end
    if (cyc_n < 4096) begin
      rd_log[cyc_n] = fifo_rd_en;
      v_log[cyc_n]  = m_valid;
      d_log[cyc_n]  = m_data;
    end
    cyc_n++;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int t0, s, pushed;
    @(negedge clk);
    #1;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_rd", int'(fifo_rd_en), 0);
    chk("rst_lvl", int'(buf_level), 0);
    chk("rst_data", int'(m_data), 0);
    @(negedge clk);
    aclr_n = 1'b1;
    #1;
    run(2);
    // single word
    t0 = cyc_n;
    m_ready = 1'b1;
    push(8'hA5);
    run(6);
    chk("t1_rd0", int'(rd_log[t0]), 1);
    chk("t1_rd1", int'(rd_log[t0+1]), 0);
    chk("t1_v1", int'(v_log[t0+1]), 0);
    chk("t1_v2", int'(v_log[t0+2]), 1);
    chk("t1_d2", int'(d_log[t0+2]), 'hA5);
    chk("t1_v3", int'(v_log[t0+3]), 0);
`ifdef STREAM_RD_CNT_EN
    chk("t1_cnt", int'(xfer_count), 1);
`endif
    // streaming
    t0 = cyc_n;
    for (int i = 0; i < 16; i++) push(8'(i));
    run(20);
    for (int i = 0; i < 20; i++) begin
      chk("t2_rd", int'(rd_log[t0+i]), int'(i < 16));
      chk("t2_valid", int'(v_log[t0+i]), int'(i >= 2 && i < 18));
      if (i >= 2 && i < 18) chk("t2_data", int'(d_log[t0+i]), i - 2);
    end
    // backpressure
    m_ready = 1'b0;
    t0 = cyc_n;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    run(10);
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(rd_log[t0+i]);
    chk("t3_rd_cnt", s, 2);
    chk("t3_lvl", int'(buf_level), 2);
    chk("t3_head", int'(m_data), 'h30);
    for (int i = 2; i < 10; i++) chk("t3_hold", int'(d_log[t0+i]), 'h30);
    m_ready = 1'b1;
    run(12);
    chk("t3_all", exp_idx, n_wr);
    // random backpressure and arrival
    pushed = 0;
    for (int k = 0; k < 1500 && !(pushed == 200 && exp_idx == n_wr); k++) begin
      if (pushed < 200 && $urandom_range(0, 1) != 0) begin
        push(8'($urandom_range(0, 255)));
        pushed++;
      end
      m_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("t4_drain", exp_idx, n_wr);
    // sync clear with a read in flight
    m_ready = 1'b0;
    run(2);
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    run(2);
    chk("t5_pre_lvl", int'(buf_level), 1);
    sclr_n = 1'b0;
    cyc();
    sclr_n = 1'b1;
    chk("t5_rd", int'(rd_log[cyc_n-1]), 0);
    chk("t5_valid", int'(m_valid), 0);
    chk("t5_lvl", int'(buf_level), 0);
`ifdef STREAM_RD_CNT_EN
    chk("t5_cnt", int'(xfer_count), 0);
`endif
    m_ready = 1'b1;
    push(8'h77);
    run(6);
    chk("t5_drain", exp_idx, n_wr);
    // asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
    run(5);
    chk("t6_pre_valid", int'(m_valid), 1);
    aclr_n = 1'b0;
    #1;
    chk("t6_valid", int'(m_valid), 0);
    chk("t6_rd", int'(fifo_rd_en), 0);
    chk("t6_lvl", int'(buf_level), 0);
    chk("t6_data", int'(m_data), 0);
    cyc();
    aclr_n = 1'b1;
    run(2);
    push(8'h9A);
    push(8'h9B);
    run(6);
    chk("t6_drain", exp_idx, n_wr);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
